// File: rtl/reg_write_scoreboard.sv
// Register write scoreboard: tracks outstanding destination writes, flags RAW hazards,
// arbitrates issue against pending writes and decodes writebacks to one-hot write enables.
module reg_write_scoreboard #(
  parameter int unsigned ADDR_W   = 5,
  parameter bit          ZERO_REG = 1'b1,
  parameter bit          REG_OUT  = 1'b1
) (
  input  logic                      Clock,
  input  logic                      Reset,
  input  logic                      RegisterWrite,
  input  logic [ADDR_W-1:0]         WriteRegister,
  input  logic                      IssueValid,
  input  logic [ADDR_W-1:0]         IssueRegister,
  output logic                      IssueReady,
  input  logic [ADDR_W-1:0]         ReadRegA,
  input  logic [ADDR_W-1:0]         ReadRegB,
  output logic                      HazardA,
  output logic                      HazardB,
  output logic [(1<<ADDR_W)-1:0]    WriteEnable,
  output logic [(1<<ADDR_W)-1:0]    Pending,
  output logic [ADDR_W:0]           PendingCount,
  output logic                      Error
);

  localparam int unsigned NUM_REGS = 1 << ADDR_W;
  localparam int unsigned CNT_W    = ADDR_W + 1;

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic                err_q, err_d;
  logic [NUM_REGS-1:0] wb_mask_c;
  logic                wb_eff_c, iss_req_c, issue_acc_c, inc_c, dec_c;
  logic                wr_zero_c, ir_zero_c;

  assign wr_zero_c = (WriteRegister == '0);
  assign ir_zero_c = (IssueRegister == '0);
  assign wb_eff_c  = RegisterWrite && !(ZERO_REG && wr_zero_c);
  assign iss_req_c = IssueValid && !(ZERO_REG && ir_zero_c);

  // Writeback decode; a hardwired register 0 never gets an enable.
  always_comb begin
    wb_mask_c = '0;
    if (RegisterWrite) wb_mask_c[WriteRegister] = 1'b1;
    if (ZERO_REG) wb_mask_c[0] = 1'b0;
  end

  // A same-cycle writeback to the issuing register frees it for the new owner.
  assign IssueReady  = !pending_q[IssueRegister] ||
                       (RegisterWrite && (WriteRegister == IssueRegister));
  assign issue_acc_c = iss_req_c && IssueReady;

  assign HazardA = pending_q[ReadRegA] && !(RegisterWrite && (WriteRegister == ReadRegA));
  assign HazardB = pending_q[ReadRegB] && !(RegisterWrite && (WriteRegister == ReadRegB));

  // Next-state: clear on writeback, then set on issue so a same-register issue wins.
  always_comb begin
    pending_d = pending_q;
    err_d     = err_q;
    inc_c     = 1'b0;
    dec_c     = 1'b0;
    if (wb_eff_c) begin
      pending_d[WriteRegister] = 1'b0;
      if (!pending_q[WriteRegister]) err_d = 1'b1;
    end
    if (issue_acc_c) pending_d[IssueRegister] = 1'b1;
    inc_c   = issue_acc_c && !pending_q[IssueRegister];
    dec_c   = wb_eff_c && pending_q[WriteRegister] &&
              !(issue_acc_c && (IssueRegister == WriteRegister));
    count_d = count_q + CNT_W'(inc_c) - CNT_W'(dec_c);
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      pending_q <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
    end else begin
      pending_q <= pending_d;
      count_q   <= count_d;
      err_q     <= err_d;
    end
  end

  generate
    if (REG_OUT) begin : g_reg_we
      logic [NUM_REGS-1:0] we_q;
      always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) we_q <= '0;
        else        we_q <= wb_mask_c;
      end
      assign WriteEnable = we_q;
    end else begin : g_comb_we
      assign WriteEnable = wb_mask_c;
    end
  endgenerate

  assign Pending      = pending_q;
  assign PendingCount = count_q;
  assign Error        = err_q;

endmodule
